// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment display controller: periodic/forced sampling, hex or double-dabble decimal.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int DATA_W       = 24,
    parameter int REFRESH_LOG2 = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       value,
    input  logic                    mode_dec,
    input  logic                    hold,
    input  logic                    force_update,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    busy,
    output logic                    overflow,
    output logic                    update_tick
);

    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (DATA_W > DIG_W) ? DATA_W : DIG_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEX_LOAD,
        S_DEC_SHIFT,
        S_DEC_LOAD
    } state_t;

    state_t                  r_state;
    logic [REFRESH_LOG2-1:0] r_refresh;
    logic [DATA_W-1:0]       r_shreg;
    logic [DIG_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_ovf_pend;
    logic [DIG_W-1:0]        r_digits;
    logic                    r_dash;
    logic                    r_busy;
    logic                    r_overflow;
    logic                    r_update_tick;

    logic                    w_request;
    logic [EXT_W-1:0]        w_hex_ext;
    logic                    w_hex_ovf;
    logic [DIG_W-1:0]        w_bcd_adj;
    logic [7*NUM_DIGITS-1:0] w_seg;
`ifdef SEG7_LZ_BLANK_EN
    logic                    w_lead_zero;
`endif

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // force_update bypasses hold; requests outside IDLE are simply lost
    assign w_request = ((r_refresh == '0) && !hold) || force_update;

    assign w_hex_ext = EXT_W'(r_shreg);
    assign w_hex_ovf = |(w_hex_ext >> DIG_W);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_bcd         <= '0;
            r_bit_cnt     <= '0;
            r_ovf_pend    <= 1'b0;
            r_digits      <= {NUM_DIGITS{4'hF}};
            r_dash        <= 1'b0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_update_tick <= 1'b0;
        end else begin
            r_update_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        r_shreg <= value;
                        r_busy  <= 1'b1;
                        if (mode_dec) begin
                            r_bcd      <= '0;
                            r_bit_cnt  <= CNT_W'(DATA_W);
                            r_ovf_pend <= 1'b0;
                            r_state    <= S_DEC_SHIFT;
                        end else begin
                            r_state <= S_HEX_LOAD;
                        end
                    end
                end
                S_HEX_LOAD: begin
                    r_digits      <= w_hex_ext[DIG_W-1:0];
                    r_dash        <= w_hex_ovf;
                    r_overflow    <= w_hex_ovf;
                    r_update_tick <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                S_DEC_SHIFT: begin
                    // a 1 leaving the top BCD nibble means the value needs more digits
                    r_bcd      <= {w_bcd_adj[DIG_W-2:0], r_shreg[DATA_W-1]};
                    r_shreg    <= r_shreg << 1;
                    r_ovf_pend <= r_ovf_pend | w_bcd_adj[DIG_W-1];
                    r_bit_cnt  <= r_bit_cnt - 1'b1;
                    if (r_bit_cnt == CNT_W'(1)) begin
                        r_state <= S_DEC_LOAD;
                    end
                end
                S_DEC_LOAD: begin
                    r_digits      <= r_bcd;
                    r_dash        <= r_ovf_pend;
                    r_overflow    <= r_ovf_pend;
                    r_update_tick <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_seg = '0;
`ifdef SEG7_LZ_BLANK_EN
        w_lead_zero = 1'b1;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_seg[7*i +: 7] = r_dash ? SEG_DASH : f_glyph(r_digits[4*i +: 4]);
`ifdef SEG7_LZ_BLANK_EN
            if (!r_dash && (i != 0) && w_lead_zero && (r_digits[4*i +: 4] == 4'h0)) begin
                w_seg[7*i +: 7] = SEG_BLANK;
            end
            if (r_digits[4*i +: 4] != 4'h0) begin
                w_lead_zero = 1'b0;
            end
`endif
        end
    end

    assign seg         = w_seg;
    assign busy        = r_busy;
    assign overflow    = r_overflow;
    assign update_tick = r_update_tick;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: arithmetic reference model feeds a queue, a monitor
// compares display, overflow, busy and update_tick timing every cycle.
module tb_seg7_display_ctrl;

    localparam int ND     = 6;
    localparam int DW     = 24;
    localparam int RL     = 4;
    localparam int PERIOD = 1 << RL;

    localparam logic [6:0]      DASH  = 7'b0111111;
    localparam logic [6:0]      BLANK = 7'b1111111;
    localparam logic [7*ND-1:0] ALL_F = {ND{7'b0001110}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   value = '0;
    logic            mode_dec = 1'b0;
    logic            hold = 1'b1;
    logic            force_update = 1'b0;
    logic [7*ND-1:0] seg;
    logic            busy;
    logic            overflow;
    logic            update_tick;

    seg7_display_ctrl #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_LOG2(RL)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .mode_dec    (mode_dec),
        .hold        (hold),
        .force_update(force_update),
        .seg         (seg),
        .busy        (busy),
        .overflow    (overflow),
        .update_tick (update_tick)
    );

    always #5 clk = ~clk;

    // 0-9, A, b, C, d, E, F, active low, bit0 = a
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_display(input longint unsigned v, input bit dec,
                                          output logic [7*ND-1:0] s, output bit ovf);
        longint unsigned base;
        longint unsigned lim;
        longint unsigned t;
        int              dig [ND];
        base = dec ? 64'd10 : 64'd16;
        lim  = 1;
        for (int i = 0; i < ND; i++) lim = lim * base;
        ovf = (v >= lim);
        t = v;
        for (int i = 0; i < ND; i++) begin
            dig[i] = int'(t % base);
            t      = t / base;
        end
        s = '0;
        for (int i = 0; i < ND; i++) begin
            s[7*i +: 7] = ovf ? DASH : glyph[dig[i]];
        end
`ifdef SEG7_LZ_BLANK_EN
        if (!ovf) begin
            for (int i = ND - 1; i >= 1; i--) begin
                if (dig[i] != 0) break;
                s[7*i +: 7] = BLANK;
            end
        end
`endif
    endfunction

    typedef struct {
        logic [7*ND-1:0] s;
        bit              ovf;
        int              due;
    } exp_t;

    exp_t            sb_q [$];
    exp_t            m_new;
    int              m_edge      = -1;
    int              m_busy_left = 0;
    int              m_dur;
    logic [7*ND-1:0] m_disp      = ALL_F;
    bit              m_ovf       = 1'b0;

    // reference model: edge k since reset release has a periodic request when k is a multiple of PERIOD
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edge      = -1;
            m_busy_left = 0;
            m_disp      = ALL_F;
            m_ovf       = 1'b0;
            sb_q.delete();
        end else begin
            m_edge++;
            if (m_busy_left != 0) begin
                m_busy_left--;
            end else if (((m_edge % PERIOD) == 0 && !hold) || force_update) begin
                m_dur = mode_dec ? DW + 1 : 1;
                model_display(longint'(value), mode_dec, m_new.s, m_new.ovf);
                m_new.due   = m_edge + m_dur;
                m_busy_left = m_dur;
                sb_q.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        bit   exp_tick;
        exp_t e;
        exp_tick = (sb_q.size() > 0) && (sb_q[0].due == m_edge);
        check("update_tick", update_tick, exp_tick);
        if (sb_q.size() > 0 && sb_q[0].due <= m_edge) begin
            e      = sb_q.pop_front();
            m_disp = e.s;
            m_ovf  = e.ovf;
        end
        check("seg", seg, m_disp);
        check("overflow", overflow, m_ovf);
        check("busy", busy, m_busy_left != 0);
    end

    task automatic pulse_force(input logic [DW-1:0] v, input bit dec);
        @(negedge clk);
        value        = v;
        mode_dec     = dec;
        force_update = 1'b1;
        @(negedge clk);
        force_update = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_budget", n < budget, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg"}, seg, ALL_F);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_tick"}, update_tick, 1'b0);
    endtask

    initial begin
        int              ticks;
        logic [7*ND-1:0] exp42;

        repeat (3) @(negedge clk);
        check_reset_state("rst_init");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pulse_force(24'h12AB3C, 1'b0);
        wait_idle(10);
        check("hex_12AB3C", seg, {glyph[1], glyph[2], glyph[10], glyph[11], glyph[3], glyph[12]});

        pulse_force(24'd987654, 1'b1);
        wait_idle(40);
        check("dec_987654", seg, {glyph[9], glyph[8], glyph[7], glyph[6], glyph[5], glyph[4]});

        pulse_force(24'd1000000, 1'b1);
        wait_idle(40);
        check("dec_ovf_flag", overflow, 1'b1);
        check("dec_ovf_seg", seg, {ND{DASH}});

        pulse_force(24'd999999, 1'b1);
        wait_idle(40);
        check("dec_999999_ovf", overflow, 1'b0);
        check("dec_999999_seg", seg, {ND{glyph[9]}});

        // second request lands while busy and must be lost
        pulse_force(24'd123456, 1'b1);
        repeat (5) @(negedge clk);
        pulse_force(24'd654321, 1'b1);
        wait_idle(40);
        check("dropped_req", seg, {glyph[1], glyph[2], glyph[3], glyph[4], glyph[5], glyph[6]});

        mode_dec = 1'b0;
        hold     = 1'b0;
        ticks    = 0;
        repeat (4 * PERIOD) begin
            @(negedge clk);
            value = value + 1'b1;
            if (update_tick) ticks++;
        end
        check("periodic_ticks", ticks, 4);

        hold = 1'b1;
        repeat (3) @(negedge clk);
        ticks = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            value = value + 1'b1;
            if (update_tick) ticks++;
        end
        check("hold_ticks", ticks, 0);

        pulse_force(24'h00BEEF, 1'b0);
        wait_idle(10);

        repeat (400) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       value = DW'($urandom);
                1:       value = DW'($urandom_range(0, 300));
                default: value = DW'($urandom_range(0, 1100000));
            endcase
            mode_dec     = $urandom_range(0, 1) == 1;
            hold         = $urandom_range(0, 3) == 0;
            force_update = $urandom_range(0, 7) == 0;
        end
        @(negedge clk);
        force_update = 1'b0;
        hold         = 1'b1;
        wait_idle(60);

        pulse_force(24'd555555, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * DW) @(negedge clk);
        check("rst_mid_no_load", seg, ALL_F);

        pulse_force(24'd42, 1'b1);
        wait_idle(40);
`ifdef SEG7_LZ_BLANK_EN
        exp42 = {BLANK, BLANK, BLANK, BLANK, glyph[4], glyph[2]};
`else
        exp42 = {glyph[0], glyph[0], glyph[0], glyph[0], glyph[4], glyph[2]};
`endif
        check("dec_42", seg, exp42);

        pulse_force(24'h000000, 1'b0);
        wait_idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
